// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS core.
//   - opcode / funct constants of the supported instruction subset
//   - state_t   : main control FSM states
//   - alu_op_t  : ALU operations
//   - helpers   : funct legality, funct -> ALU op, 16-bit sign extension
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXEC_R,
      EXEC_I,
      MEMRD,
      MEMWR,
      WB_R,
      WB_I,
      WB_MEM,
      BRANCH,
      JUMP,
      HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   function automatic logic funct_legal(input logic [5:0] funct);
      logic ok;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
         default:                                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
      alu_op_t op;
      case (funct)
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational 32-bit ALU. Arithmetic wraps; SLT is signed.
// Ports:
//   i_a, i_b : operands
//   i_op     : operation select (alu_op_t)
//   o_y      : result
module mc_alu
   import mc_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  alu_op_t     i_op,
   output logic [31:0] o_y
);

   always_comb begin
      o_y = i_a + i_b;
      case (i_op)
         ALU_ADD: o_y = i_a + i_b;
         ALU_SUB: o_y = i_a - i_b;
         ALU_AND: o_y = i_a & i_b;
         ALU_OR:  o_y = i_a | i_b;
         ALU_SLT: o_y = {31'b0, ($signed(i_a) < $signed(i_b))};
         default: o_y = i_a + i_b;
      endcase
   end

endmodule

// File: rtl/mc_core.sv
// mc_core: multicycle MIPS core (datapath + main control FSM) talking to a
// unified instruction/data memory through a req/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read instruction at PC; on completion IR<-rdata, PC<-PC+4
// DECODE | A<-rs, B<-rt, ALUOut<-branch target; dispatch on opcode
// EXEC_R | ALUOut <- A op B
// EXEC_I | ALUOut <- A + sext(imm)  (lw/sw address or addi result)
// MEMRD  | read at ALUOut; on completion MDR<-rdata
// MEMWR  | write B at ALUOut; retires on completion
// WB_R   | rd <- ALUOut, retire
// WB_I   | rt <- ALUOut, retire
// WB_MEM | rt <- MDR, retire
// BRANCH | PC <- ALUOut when beq/bne condition holds, retire
// JUMP   | PC <- {PC[31:28], IR[25:0], 00}, retire
// HALT   | illegal instruction seen; idle until reset
//
// Ports:
//   clk, reset (sync, active-high)
//   mem_req/mem_we/mem_addr/mem_wdata : request side, held stable until ready
//   mem_rdata/mem_ready               : response side
//   retire : one pulse in the last cycle of every completed instruction
//   halted : core stopped on an illegal instruction
//   pc_out : architectural PC
module mc_core
   import mc_pkg::*;
#(
   parameter int          ADDR_W   = 16,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic              halted,
   output logic [31:0]       pc_out
);

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_mdr;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_alu_out;
   logic [31:0] r_rf [32];

   logic [5:0]  w_op;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [5:0]  w_funct;
   logic [31:0] w_imm;

   logic [31:0] w_alu_a;
   logic [31:0] w_alu_b;
   alu_op_t     w_alu_op;
   logic [31:0] w_alu_y;

   logic        w_req;
   logic        w_retire;
   logic        w_take;
   logic [31:0] w_addr;
   logic        w_unused;

   assign w_op    = r_ir[31:26];
   assign w_rs    = r_ir[25:21];
   assign w_rt    = r_ir[20:16];
   assign w_rd    = r_ir[15:11];
   assign w_funct = r_ir[5:0];
   assign w_imm   = sext16(r_ir[15:0]);

   assign w_take  = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

   // One ALU serves PC increment, branch-target and execute steps.
   always_comb begin
      w_alu_a  = r_a;
      w_alu_b  = r_b;
      w_alu_op = funct_to_alu(w_funct);
      case (r_state)
         FETCH: begin
            w_alu_a  = r_pc;
            w_alu_b  = 32'd4;
            w_alu_op = ALU_ADD;
         end
         DECODE: begin
            w_alu_a  = r_pc;
            w_alu_b  = {w_imm[29:0], 2'b00};
            w_alu_op = ALU_ADD;
         end
         EXEC_I: begin
            w_alu_a  = r_a;
            w_alu_b  = w_imm;
            w_alu_op = ALU_ADD;
         end
         default: ;
      endcase
   end

   mc_alu u_alu (
      .i_a  (w_alu_a),
      .i_b  (w_alu_b),
      .i_op (w_alu_op),
      .o_y  (w_alu_y)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_req    = 1'b0;
      w_retire = 1'b0;
      case (r_state)
         FETCH: begin
            w_req = 1'b1;
            if (mem_ready) w_next = DECODE;
         end
         DECODE: begin
            case (w_op)
               OP_RTYPE:            w_next = funct_legal(w_funct) ? EXEC_R : HALT;
               OP_LW, OP_SW, OP_ADDI: w_next = EXEC_I;
               OP_BEQ, OP_BNE:      w_next = BRANCH;
               OP_J:                w_next = JUMP;
               default:             w_next = HALT;
            endcase
         end
         EXEC_R: w_next = WB_R;
         EXEC_I: begin
            if (w_op == OP_LW)      w_next = MEMRD;
            else if (w_op == OP_SW) w_next = MEMWR;
            else                    w_next = WB_I;
         end
         MEMRD: begin
            w_req = 1'b1;
            if (mem_ready) w_next = WB_MEM;
         end
         MEMWR: begin
            w_req = 1'b1;
            if (mem_ready) begin
               w_next   = FETCH;
               w_retire = 1'b1;
            end
         end
         WB_R, WB_I, WB_MEM, BRANCH, JUMP: begin
            w_next   = FETCH;
            w_retire = 1'b1;
         end
         HALT:    w_next = HALT;
         default: w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_mdr     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu_out <= '0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (mem_ready) begin
                  r_ir <= mem_rdata;
                  r_pc <= w_alu_y;
               end
            end
            DECODE: begin
               r_a       <= r_rf[w_rs];
               r_b       <= r_rf[w_rt];
               r_alu_out <= w_alu_y;
            end
            EXEC_R, EXEC_I: r_alu_out <= w_alu_y;
            MEMRD: begin
               if (mem_ready) r_mdr <= mem_rdata;
            end
            WB_R: begin
               if (w_rd != 5'd0) r_rf[w_rd] <= r_alu_out;
            end
            WB_I: begin
               if (w_rt != 5'd0) r_rf[w_rt] <= r_alu_out;
            end
            WB_MEM: begin
               if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
            end
            BRANCH: begin
               if (w_take) r_pc <= r_alu_out;
            end
            JUMP: r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            default: ;
         endcase
      end
   end

   // Address sources do not move while a transfer waits: PC only updates on
   // fetch completion, ALUOut is untouched in the memory states.
   assign w_addr    = (r_state == FETCH) ? r_pc : r_alu_out;
   assign mem_addr  = {w_addr[ADDR_W-1:2], 2'b00};
   assign mem_wdata = r_b;
   assign w_unused  = ^w_addr;

   // Reset masks every strobe so a pending transfer is dropped cleanly.
   assign mem_req = w_req & ~reset;
   assign mem_we  = (r_state == MEMWR) & ~reset;
   assign retire  = w_retire & ~reset;
   assign halted  = (r_state == HALT) & ~reset;
   assign pc_out  = reset ? RESET_PC : r_pc;

endmodule

// File: tb/tb_mc_core.sv
module tb_mc_core;

   localparam int          ADDR_W    = 16;
   localparam logic [31:0] RESET_PC  = 32'h0;
   localparam int          MEM_WORDS = 2048;
   localparam int          N_WAITS   = 4096;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;
   logic              mem_ready = 1'b0;
   logic              retire;
   logic              halted;
   logic [31:0]       pc_out;

   mc_core #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .retire    (retire),
      .halted    (halted),
      .pc_out    (pc_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   // memory, wait schedule, observed stores
   logic [31:0] mem [MEM_WORDS];
   int unsigned waits [N_WAITS];
   int          widx = 0;
   bit          force_rdy = 1'b0;
   logic [31:0] act_st_addr [$];
   logic [31:0] act_st_data [$];

   // reference model results
   logic [31:0] mm [MEM_WORDS];
   logic [31:0] exp_pc_q [$];
   int          exp_cyc_q [$];
   logic [31:0] exp_st_addr [$];
   logic [31:0] exp_st_data [$];

   // Memory responder: runs just after the falling edge, so stimulus driven on
   // the falling edge has settled. Each transfer takes its wait count from the
   // pre-drawn schedule, in order.
   initial begin
      int unsigned cnt;
      int unsigned cur;
      bit          busy;
      bit          done;
      int          idx;
      cnt = 0; cur = 0; busy = 0; done = 0;
      forever begin
         @(negedge clk);
         #1;
         if (done) begin
            mem_ready = 1'b0;
            done = 0;
         end
         if (force_rdy) begin
            mem_ready = 1'b1;
            busy = 0;
            done = 1;
         end else if (mem_req) begin
            if (!busy) begin
               busy = 1;
               cnt  = 0;
               cur  = waits[widx % N_WAITS];
               widx++;
            end
            if (cnt == cur) begin
               idx = int'(mem_addr[12:2]);
               mem_ready = 1'b1;
               done = 1;
               busy = 0;
               mem_rdata = mem[idx];
               if (mem_we) begin
                  mem[idx] = mem_wdata;
                  act_st_addr.push_back(32'(mem_addr));
                  act_st_data.push_back(mem_wdata);
               end
            end else begin
               cnt++;
            end
         end else begin
            busy = 0;
         end
      end
   end

   // ISA-level interpreter: walks the program in a private copy of memory and
   // records, per instruction, its fetch PC and its cycle count given the waits.
   task automatic model_run();
      logic [31:0] regs [32];
      logic [31:0] pc, npc, ins, a, b, imm, res, addr;
      int          k, w, wd, cyc;
      bit          illegal, fin;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      for (int i = 0; i < MEM_WORDS; i++) mm[i] = mem[i];
      exp_pc_q.delete(); exp_cyc_q.delete();
      exp_st_addr.delete(); exp_st_data.delete();
      pc = RESET_PC; k = 0; fin = 0;
      for (int step = 0; step < 2000 && !fin; step++) begin
         ins = mm[pc[12:2]];
         w = int'(waits[k]); k++;
         exp_pc_q.push_back(pc);
         a   = regs[ins[25:21]];
         b   = regs[ins[20:16]];
         imm = {{16{ins[15]}}, ins[15:0]};
         npc = pc + 4;
         illegal = 0; cyc = 0; res = '0;
         case (ins[31:26])
            6'h00: begin
               case (ins[5:0])
                  6'h20: res = a + b;
                  6'h22: res = a - b;
                  6'h24: res = a & b;
                  6'h25: res = a | b;
                  6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  default: illegal = 1;
               endcase
               if (!illegal) begin
                  if (ins[15:11] != 0) regs[ins[15:11]] = res;
                  cyc = 4 + w;
               end
            end
            6'h08: begin
               if (ins[20:16] != 0) regs[ins[20:16]] = a + imm;
               cyc = 4 + w;
            end
            6'h23: begin
               addr = (a + imm) & ~32'd3;
               wd = int'(waits[k]); k++;
               if (ins[20:16] != 0) regs[ins[20:16]] = mm[addr[12:2]];
               cyc = 5 + w + wd;
            end
            6'h2B: begin
               addr = (a + imm) & ~32'd3;
               wd = int'(waits[k]); k++;
               mm[addr[12:2]] = b;
               exp_st_addr.push_back(addr & 32'h0000_FFFF);
               exp_st_data.push_back(b);
               cyc = 4 + w + wd;
            end
            6'h04: begin
               if (a == b) npc = pc + 4 + (imm * 4);
               cyc = 3 + w;
            end
            6'h05: begin
               if (a != b) npc = pc + 4 + (imm * 4);
               cyc = 3 + w;
            end
            6'h02: begin
               npc = {npc[31:28], ins[25:0], 2'b00};
               cyc = 3 + w;
            end
            default: illegal = 1;
         endcase
         if (illegal) begin
            cyc = 3 + w;
            fin = 1;
         end
         exp_cyc_q.push_back(cyc);
         pc = npc;
      end
   endtask

   task automatic run_and_check(input string name);
      int                cyc, unstable, hold_bad, mism, n_st;
      bit                last, p_wait;
      logic [ADDR_W-1:0] p_addr;
      logic              p_we;
      logic [31:0]       p_wd;
      model_run();
      act_st_addr.delete(); act_st_data.delete();
      @(negedge clk);
      reset = 1'b1; force_rdy = 1'b0; widx = 0;
      @(negedge clk);
      #2;
      chk({name, "_rst_req"},    32'(mem_req), 0);
      chk({name, "_rst_we"},     32'(mem_we),  0);
      chk({name, "_rst_retire"}, 32'(retire),  0);
      chk({name, "_rst_halted"}, 32'(halted),  0);
      chk({name, "_rst_pc"},     pc_out,       RESET_PC);
      @(negedge clk);
      reset = 1'b0;
      #2;
      unstable = 0;
      for (int i = 0; i < exp_pc_q.size(); i++) begin
         last = (i == exp_pc_q.size() - 1);
         chk({name, "_fetch_addr"}, 32'(mem_addr), exp_pc_q[i] & 32'h0000_FFFF);
         chk({name, "_fetch_req"},  {30'b0, mem_req, mem_we}, 32'b10);
         chk({name, "_pc_out"},     pc_out, exp_pc_q[i]);
         cyc = 1;
         while (!(retire || halted) && cyc < 60) begin
            p_wait = mem_req && !mem_ready;
            p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
            @(negedge clk);
            #2;
            cyc++;
            if (p_wait && (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wd))
               unstable++;
         end
         chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc_q[i]));
         chk({name, "_end_kind"}, {30'b0, retire, halted}, last ? 32'b01 : 32'b10);
         if (cyc >= 60) break;
         if (!last) begin
            @(negedge clk);
            #2;
         end
      end
      hold_bad = 0;
      repeat (20) begin
         @(negedge clk);
         #2;
         if (!halted || mem_req || retire) hold_bad++;
      end
      chk({name, "_halt_hold"}, 32'(hold_bad), 0);
      chk({name, "_stable"},    32'(unstable), 0);
      chk({name, "_st_count"},  32'(act_st_addr.size()), 32'(exp_st_addr.size()));
      n_st = (act_st_addr.size() < exp_st_addr.size()) ? act_st_addr.size() : exp_st_addr.size();
      for (int i = 0; i < n_st; i++) begin
         chk({name, "_st_addr"}, act_st_addr[i], exp_st_addr[i]);
         chk({name, "_st_data"}, act_st_data[i], exp_st_data[i]);
      end
      mism = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== mm[i]) mism++;
      chk({name, "_mem_image"}, 32'(mism), 0);
   endtask

   task automatic fill_mem_random();
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
   endtask

   task automatic load_directed();
      fill_mem_random();
      mem[0]  = 32'h2001_0005;   // addi $1,$0,5
      mem[1]  = 32'h2002_FFFD;   // addi $2,$0,-3
      mem[2]  = 32'h0022_1820;   // add  $3,$1,$2
      mem[3]  = 32'hAC03_0100;   // sw   $3,0x100($0)
      mem[4]  = 32'h1021_0002;   // beq  $1,$1,+2   (at 0x10 -> 0x1C)
      mem[5]  = 32'hFC00_0000;
      mem[6]  = 32'hFC00_0000;
      mem[7]  = 32'h1421_0002;   // bne  $1,$1,+2   (falls through)
      mem[8]  = 32'h8C04_0100;   // lw   $4,0x100($0)
      mem[9]  = 32'h2000_0007;   // addi $0,$0,7
      mem[10] = 32'hAC04_0104;   // sw   $4,0x104($0)
      mem[11] = 32'hAC00_0108;   // sw   $0,0x108($0)
      mem[12] = 32'h0800_0040;   // j    0x100 (word there is 2 -> illegal funct)
   endtask

   task automatic gen_random(input int n);
      int          ty, rs, rt, rd;
      logic [5:0]  fn;
      logic [31:0] ins;
      fill_mem_random();
      for (int i = 0; i < n; i++) begin
         ty = $urandom_range(0, 9);
         rs = $urandom_range(0, 7);
         rt = $urandom_range(0, 7);
         rd = $urandom_range(0, 7);
         case ($urandom_range(0, 4))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            3:       fn = 6'h25;
            default: fn = 6'h2A;
         endcase
         case (ty)
            0, 1, 2: ins = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
            3, 4:    ins = {6'h08, 5'(rs), 5'(rt), 16'($urandom)};
            5:       ins = {6'h23, 5'd0, 5'(rt), 16'(32'h800 + $urandom_range(0, 32'h7FF))};
            6:       ins = {6'h2B, 5'd0, 5'(rt), 16'(32'h800 + $urandom_range(0, 32'h7FF))};
            7:       ins = {6'h04, 5'(rs), 5'(rt), 16'($urandom_range(0, 3))};
            8:       ins = {6'h05, 5'(rs), 5'(rt), 16'($urandom_range(0, 3))};
            default: ins = {6'h02, 26'(i + 1 + int'($urandom_range(0, 3)))};
         endcase
         mem[i] = ins;
      end
      for (int j = 0; j < 4; j++) mem[n + j] = 32'h0000_0020;
      for (int r = 1; r < 8; r++) mem[n + 3 + r] = {6'h2B, 5'd0, 5'(r), 16'(32'h1800 + 4 * r)};
      mem[n + 11] = 32'hFC00_0000;
   endtask

   initial begin
      bit seen;

      // directed program, zero-wait memory
      for (int i = 0; i < N_WAITS; i++) waits[i] = 0;
      load_directed();
      run_and_check("dir0");
      chk("dir0_sw_addr",  act_st_addr.size() > 0 ? act_st_addr[0] : 32'hDEAD, 32'h0100);
      chk("dir0_sw3_data", act_st_data.size() > 0 ? act_st_data[0] : 32'hDEAD, 32'd2);
      chk("dir0_lw4_data", act_st_data.size() > 1 ? act_st_data[1] : 32'hDEAD, 32'd2);
      chk("dir0_r0_zero",  act_st_data.size() > 2 ? act_st_data[2] : 32'hDEAD, 32'd0);
      chk("dir0_sw_cyc",   32'(exp_cyc_q[3]), 32'd4);
      chk("dir0_lw_cyc",   32'(exp_cyc_q[6]), 32'd5);

      // same program, 3 wait cycles on every transfer
      for (int i = 0; i < N_WAITS; i++) waits[i] = 3;
      load_directed();
      run_and_check("dir3");
      chk("dir3_lw_cyc", 32'(exp_cyc_q[6]), 32'd11);

      // randomized programs and wait states
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N_WAITS; i++)
            waits[i] = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
         gen_random(40);
         run_and_check("rnd");
      end

      // reset while a store waits; ready arrives only in the reset cycle
      fill_mem_random();
      mem[0]  = 32'h2001_0055;   // addi $1,$0,0x55
      mem[1]  = 32'hAC01_0100;   // sw   $1,0x100($0)
      mem[2]  = 32'hFC00_0000;
      mem[64] = 32'h0;
      for (int i = 0; i < N_WAITS; i++) waits[i] = 0;
      waits[2] = 10;
      act_st_addr.delete(); act_st_data.delete();
      @(negedge clk);
      reset = 1'b1; widx = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         #2;
         if (mem_req && mem_we) seen = 1;
      end
      chk("rmw_reached", 32'(seen), 1);
      chk("rmw_addr",    32'(mem_addr), 32'h0100);
      chk("rmw_wdata",   mem_wdata, 32'h55);
      @(negedge clk);
      #2;
      chk("rmw_waiting", {29'b0, mem_req, mem_we, mem_ready}, 32'b110);
      @(negedge clk);
      reset = 1'b1; force_rdy = 1'b1;
      #2;
      chk("rmw_rst_req",    32'(mem_req), 0);
      chk("rmw_rst_we",     32'(mem_we),  0);
      chk("rmw_rst_retire", 32'(retire),  0);
      chk("rmw_rst_pc",     pc_out, RESET_PC);
      @(negedge clk);
      reset = 1'b0; force_rdy = 1'b0;
      #2;
      chk("rmw_refetch",      {30'b0, mem_req, mem_we}, 32'b10);
      chk("rmw_refetch_addr", 32'(mem_addr), RESET_PC & 32'h0000_FFFF);
      chk("rmw_mem_intact",   mem[64], 32'h0);
      chk("rmw_no_store",     32'(act_st_addr.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multicycle MIPS core: datapath, main control FSM and ALU in one block, with a req/ready memory handshake that tolerates variable memory latency. It sits between the top level and a unified instruction/data memory and supersedes the split datapath/controller pair. Beyond that pair it adds configurable address width and reset vector, `bne`/`addi`, memory wait states, a retire strobe and halt-on-illegal-opcode.

## Interface
Parameters:
- `ADDR_W`, 16: memory byte-address width; `mem_addr = addr[ADDR_W-1:0]`.
- `RESET_PC`, 32'h0: PC value loaded on reset.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `mem_req`, out, 1: memory transfer request.
- `mem_we`, out, 1: 1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`, out, ADDR_W: word-aligned byte address.
- `mem_wdata`, out, 32: store data.
- `mem_rdata`, in, 32: read data; sampled on a completing read.
- `mem_ready`, in, 1: transfer completes in a cycle with `mem_req & mem_ready`.
- `retire`, out, 1: one-cycle pulse per completed instruction.
- `halted`, out, 1: sticky; core stopped on an illegal instruction.
- `pc_out`, out, 32: architectural PC, for debug.

## Operation
- Instructions:
  - R-type (op 0): funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I/J-type: lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02.
  - Any other op, or an unlisted funct with op 0, is illegal.
- Arithmetic: 32-bit and wraps with no overflow trap. `slt` is signed. Immediates are sign-extended.
- Register file: 32×32. `$0` always reads 0 and writes to it are discarded.
- FSM states and transitions:
  - FETCH: read at PC. On completion: IR←rdata, PC←PC+4.
  - DECODE: A←rs, B←rt, ALUOut←PC+(sext(imm)<<2), i.e. branch target.
  - From DECODE, by op: R→EXEC_R; lw/sw/addi→EXEC_I; beq/bne→BRANCH; j→JUMP; illegal→HALT.
  - EXEC_R: ALUOut←A op B, then →WB_R.
  - EXEC_I: ALUOut←A+sext(imm). Then lw→MEMRD, sw→MEMWR, addi→WB_I.
  - MEMRD: read at ALUOut. On completion: MDR←rdata, →WB_MEM.
  - MEMWR: write B to ALUOut. On completion →FETCH, retire.
  - WB_R: rd←ALUOut, →FETCH, retire.
  - WB_I: rt←ALUOut, →FETCH, retire.
  - WB_MEM: rt←MDR, →FETCH, retire.
  - BRANCH: if condition holds (beq: A==B; bne: A!=B), PC←ALUOut. →FETCH, retire.
  - JUMP: PC←{PC[31:28], IR[25:0], 2'b00}. →FETCH, retire.
  - HALT: terminal until reset. `halted`=1, `mem_req`=0, no retire.
- Memory request behaviour:
  - `mem_req` is high only in FETCH, MEMRD and MEMWR, and is gated low while `reset`=1.
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable from the cycle `mem_req` rises until the completing cycle.
  - The FSM holds in a memory state while `mem_ready`=0.
- Misaligned addresses: the low two address bits are forced to 0.

## Timing
- Reset values: PC=RESET_PC, IR=0, all registers 0, state=FETCH.
- Outputs during the reset cycle: `mem_req`=0, `mem_we`=0, `retire`=0, `halted`=0, `pc_out`=RESET_PC.
- First `mem_req` is in the first cycle after `reset` falls.
- Cycle counts with zero-wait memory (`mem_ready` tied 1): R-type 4, addi 4, sw 4, lw 5, beq/bne 3, j 3.
- Each memory wait cycle adds exactly 1 cycle.
- `retire` is high in the instruction's last cycle. The next cycle is FETCH of the next PC.
- Register, PC and memory effects are visible at the edge ending the state.
- Reset mid-operation: reset wins in every state. An unacknowledged transfer is abandoned and no write occurs, because `mem_req` is low during reset. A `mem_ready` arriving in a reset cycle is ignored.

## Structure
- Package `mc_pkg`:
  - opcode and funct constants;
  - the state enum (FETCH…HALT);
  - the ALU-op enum (ADD, SUB, AND, OR, SLT).
- Sub-module `mc_alu`: combinational, 32-bit, ALU-op in, result out.
- Register file, IR, MDR, A/B and ALUOut are registers inside `mc_core`.

## Test plan
- Zero-wait arithmetic: `addi $1,$0,5` (20010005), `addi $2,$0,-3` (2002FFFD), `add $3,$1,$2` (00221820) → `$3`=2. Three retire pulses, spaced 4 cycles apart.
- Store/load with 3 wait cycles per transfer: `$3`=2, `sw $3,0x100($0)`, then `lw $4,0x100($0)`.
  - Store: `mem_we`=1, `mem_addr`=0x0100, `mem_wdata`=2; signals held stable while waiting.
  - Load: `$4`=2, completes in 5+6 cycles.
- Branches at PC 0x10:
  - `beq $1,$1,+2` → next fetch at 0x1C.
  - `bne $1,$1,+2` → next fetch at 0x14.
  - Each takes 3 cycles.
- Jump: `j` with target field 0x40 → next `mem_addr`=0x0100. Also `addi $0,$0,7` → `$0` still reads 0.
- Illegal opcode 0x3F → after DECODE, `halted`=1, `mem_req`=0 for 20+ cycles, no retire. Reset → `halted`=0, fetch at RESET_PC.
- Reset asserted during a MEMWR wait (`mem_ready`=0, then `mem_ready`=1 in the reset cycle) → memory unchanged; next `mem_req` is a read at RESET_PC.
